bus_input_reader: RTL

Bus-read peripheral: the processor reads board inputs through it over the shared 8-bit address/data bus. It synchronises and debounces 8 slide switches and 4 push buttons, latches button-press events, and raises a processor interrupt on each new press. It drives BUS_DATA only during a matching read; otherwise it leaves the bus high-Z.

---
 rtl/bus_input_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/bus_input_reader.sv
// Bus-mapped reader for debounced slide switches and push buttons, with sticky
// press events, clear-on-read of the event register and a press interrupt.
module bus_input_reader #(
  parameter logic [7:0]  BASE_ADDR    = 8'hE0,
  parameter int unsigned DEBOUNCE_MAX = 99999,
  parameter int unsigned TICK_WIDTH   = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic       INTERRUPT_RAISE,
  input  logic       INTERRUPT_ACK
);

  typedef enum logic {IDLE = 1'b0, RAISED = 1'b1} irqState_t;

  logic [11:0]           syncA_r, syncB_r, sample_r, debounced_r;
  logic [11:0]           agree_s, debouncedNext_s;
  logic [TICK_WIDTH-1:0] tickCount_r;
  logic                  tick_s;
  logic [3:0]            event_r, rise_s, eventClear_s;
  logic [7:0]            offset_s, readMux_s, rdData_r;
  logic                  hit_s, driveEn_r, interruptRaise_r;
  irqState_t             state_r, stateNext_s;

  // Debounce update, button rise detection and read decode
  always_comb begin
    tick_s          = (tickCount_r == TICK_WIDTH'(DEBOUNCE_MAX));
    agree_s         = ~(syncB_r ^ sample_r);
    debouncedNext_s = debounced_r;
    if (tick_s) begin
      debouncedNext_s = (syncB_r & agree_s) | (debounced_r & ~agree_s);
    end else begin
      debouncedNext_s = debounced_r;
    end
    rise_s   = debouncedNext_s[11:8] & ~debounced_r[11:8];
    offset_s = BUS_ADDR - BASE_ADDR;
    hit_s    = (BUS_WE == 1'b0) && (offset_s <= 8'd2);
    case (offset_s)
      8'd0:    readMux_s = debounced_r[7:0];
      8'd1:    readMux_s = {4'b0000, event_r};
      8'd2:    readMux_s = {4'b0000, debounced_r[11:8]};
      default: readMux_s = 8'h00;
    endcase
    // Only the bits actually returned are cleared; a rise on this edge survives
    if (hit_s && (offset_s == 8'd1)) begin
      eventClear_s = event_r;
    end else begin
      eventClear_s = 4'b0000;
    end
  end

  // Interrupt next-state logic
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (|rise_s) stateNext_s = RAISED;
        else         stateNext_s = IDLE;
      end
      RAISED: begin
        if (INTERRUPT_ACK && !(|rise_s)) stateNext_s = IDLE;
        else                             stateNext_s = RAISED;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Synchronisers, sample tick, debounced state and sticky events
  always_ff @(posedge CLK) begin
    if (RESET) begin
      syncA_r     <= 12'h000;
      syncB_r     <= 12'h000;
      sample_r    <= 12'h000;
      debounced_r <= 12'h000;
      tickCount_r <= {TICK_WIDTH{1'b0}};
      event_r     <= 4'b0000;
    end else begin
      syncA_r     <= {BUTTONS, SWITCHES};
      syncB_r     <= syncA_r;
      tickCount_r <= tick_s ? {TICK_WIDTH{1'b0}} : tickCount_r + TICK_WIDTH'(1);
      if (tick_s) sample_r <= syncB_r;
      debounced_r <= debouncedNext_s;
      event_r     <= (event_r & ~eventClear_s) | rise_s;
    end
  end

  // Read capture: data and drive enable for the cycle after a hit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdData_r  <= 8'h00;
      driveEn_r <= 1'b0;
    end else if (hit_s) begin
      rdData_r  <= readMux_s;
      driveEn_r <= 1'b1;
    end else begin
      driveEn_r <= 1'b0;
    end
  end

  // Interrupt state and registered request output
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r          <= IDLE;
      interruptRaise_r <= 1'b0;
    end else begin
      state_r          <= stateNext_s;
      interruptRaise_r <= (stateNext_s == RAISED);
    end
  end

  assign BUS_DATA        = driveEn_r ? rdData_r : 8'hzz;
  assign INTERRUPT_RAISE = interruptRaise_r;

endmodule
